// File: rtl/password_lock_fsm.sv
// Switch-entry password lock: sync, edge-detect, digit decode, compare,
// failed-attempt counting with timed lockout and relock-on-keypress.
module password_lock_fsm #(
    parameter int N_SW        = 10,
    parameter int DIGITS      = 4,
    localparam int DW         = $clog2(N_SW),
    localparam int CW         = $clog2(DIGITS + 1),
    parameter logic [DIGITS*DW-1:0] PASSWORD = 16'h5173,
    parameter int MAX_TRIES   = 3,
    localparam int FW         = $clog2(MAX_TRIES + 1),
    parameter int LOCK_CYCLES = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] switches,
    output logic            key_strobe,
    output logic [DW-1:0]   last_digit,
    output logic [CW-1:0]   entry_count,
    output logic            unlocked,
    output logic            err_pulse,
    output logic            locked_out,
    output logic [FW-1:0]   fail_count
);

    localparam int TW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ENTRY,
        OPEN,
        LOCKOUT
    } state_e;

    state_e                 state_q;
    logic [N_SW-1:0]        s1_q, s2_q, s3_q;
    logic [DIGITS*DW-1:0]   dig_q, dig_d;
    logic                   bad_q;
    logic [TW-1:0]          timer_q;

    logic                   key_ev;
    logic                   key_ok;
    logic [DW-1:0]          key_dig;
    logic                   last_pos;
    logic                   match;
    logic [FW-1:0]          fail_inc;

    // Two-flop synchroniser plus one history stage for press detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= switches;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Key event on all-released to any-pressed; one-hot press gives a digit
    always_comb begin
        key_ev  = (s2_q != '0) && (s3_q == '0);
        key_ok  = ($countones(s2_q) == 1);
        key_dig = '1;
        if (key_ok) begin
            for (int i = 0; i < N_SW; i++) begin
                if (s2_q[i]) key_dig = DW'(i);
            end
        end
    end

    // Stored sequence with the incoming digit merged in, for same-edge compare
    always_comb begin
        dig_d = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (entry_count == CW'(i)) dig_d[i*DW +: DW] = key_dig;
        end
        last_pos = (entry_count == CW'(DIGITS - 1));
        match    = (dig_d == PASSWORD) && key_ok && !bad_q;
        fail_inc = (fail_count == FW'(MAX_TRIES)) ? fail_count
                                                  : fail_count + FW'(1);
    end

    // Lock state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTRY;
            dig_q       <= '0;
            bad_q       <= 1'b0;
            timer_q     <= '0;
            key_strobe  <= 1'b0;
            last_digit  <= '0;
            entry_count <= '0;
            unlocked    <= 1'b0;
            err_pulse   <= 1'b0;
            locked_out  <= 1'b0;
            fail_count  <= '0;
        end else begin
            key_strobe <= 1'b0;
            err_pulse  <= 1'b0;
            unique case (state_q)
                ENTRY: begin
                    if (key_ev) begin
                        key_strobe <= 1'b1;
                        last_digit <= key_dig;
                        dig_q      <= dig_d;
                        if (last_pos) begin
                            entry_count <= '0;
                            bad_q       <= 1'b0;
                            if (match) begin
                                state_q    <= OPEN;
                                unlocked   <= 1'b1;
                                fail_count <= '0;
                            end else begin
                                err_pulse  <= 1'b1;
                                fail_count <= fail_inc;
                                if (fail_inc == FW'(MAX_TRIES)) begin
                                    state_q    <= LOCKOUT;
                                    timer_q    <= TW'(LOCK_CYCLES);
                                    locked_out <= 1'b1;
                                end
                            end
                        end else begin
                            entry_count <= entry_count + CW'(1);
                            bad_q       <= bad_q | !key_ok;
                        end
                    end
                end
                OPEN: begin
                    if (key_ev) begin
                        key_strobe <= 1'b1;
                        last_digit <= key_dig;
                        unlocked   <= 1'b0;
                        state_q    <= ENTRY;
                    end
                end
                LOCKOUT: begin
                    if (timer_q == TW'(1)) begin
                        timer_q    <= '0;
                        locked_out <= 1'b0;
                        fail_count <= '0;
                        state_q    <= ENTRY;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= ENTRY;
            endcase
        end
    end

endmodule
